issue_scoreboard: RTL



---
 rtl/inst_package.sv | 41 ++++
 rtl/sb_counter.sv | 25 ++
 rtl/issue_scoreboard.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/inst_package.sv
// Shared instruction-level definitions: opcodes, exec types, latency classes
// and default pipeline latencies used by decode-side hazard logic.
package inst_package;

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_LI    = 6'd2,
    OP_LD    = 6'd3,
    OP_ST    = 6'd4,
    OP_BL    = 6'd5,
    OP_IN    = 6'd6,
    OP_FADD  = 6'd7,
    OP_FSUB  = 6'd8,
    OP_FMUL  = 6'd9,
    OP_FDIV  = 6'd10,
    OP_FSQRT = 6'd11,
    OP_FTOI  = 6'd12,
    OP_ITOF  = 6'd13
  } opcode_e;

  typedef enum logic [1:0] {
    EX_INT = 2'd0,
    EX_LSU = 2'd1,
    EX_FPU = 2'd2,
    EX_BRU = 2'd3
  } exec_e;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_LD  = 2'd1,
    CLS_FPU = 2'd2,
    CLS_DIV = 2'd3
  } cls_e;

  localparam int unsigned DEF_LAT_ALU = 2;
  localparam int unsigned DEF_LAT_LD  = 3;
  localparam int unsigned DEF_LAT_FPU = 4;
  localparam int unsigned DEF_LAT_DIV = 16;

endpackage

// File: rtl/sb_counter.sv
// Countdown register: loads a value, otherwise decrements and holds at zero.
module sb_counter #(
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-slot issue scoreboard: per-register countdowns, FDIV arbitration, interlock.
// Optional stall counters are enabled with `define SCOREBOARD_PERF_EN.
module issue_scoreboard
  import inst_package::*;
#(
  parameter int unsigned LAT_ALU = DEF_LAT_ALU,
  parameter int unsigned LAT_LD  = DEF_LAT_LD,
  parameter int unsigned LAT_FPU = DEF_LAT_FPU,
  parameter int unsigned LAT_DIV = DEF_LAT_DIV
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       valid,
  input  logic       flush,
  input  logic [2:0] u_src_use,
  input  logic [2:0] l_src_use,
  input  logic [4:0] u_rs,
  input  logic [4:0] u_ra,
  input  logic [4:0] u_rb,
  input  logic [4:0] l_rs,
  input  logic [4:0] l_ra,
  input  logic [4:0] l_rb,
  input  logic [4:0] u_rt,
  input  logic [4:0] l_rt,
  input  logic       u_we,
  input  logic       l_we,
  input  logic [1:0] u_cls,
  input  logic [1:0] l_cls,
  output logic       interlock,
  output logic       issue,
  output logic       div_busy,
  output logic       bundle_err
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] div_stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(LAT_DIV + 1);

  // Counters hold L-1 after issue so a consumer issues exactly L cycles later.
  function automatic logic [CW-1:0] lat_of(input logic [1:0] cls);
    logic [CW-1:0] v;
    case (cls_e'(cls))
      CLS_ALU: v = CW'(LAT_ALU - 1);
      CLS_LD:  v = CW'(LAT_LD - 1);
      CLS_FPU: v = CW'(LAT_FPU - 1);
      default: v = CW'(LAT_DIV - 1);
    endcase
    return v;
  endfunction

  logic [CW-1:0] w_cnt [32];
  logic [CW-1:0] w_load_val [32];
  logic [31:0]   w_load;
  logic [31:0]   w_hit_u;
  logic [31:0]   w_hit_l;
  logic [CW-1:0] w_lat_u;
  logic [CW-1:0] w_lat_l;
  logic [CW-1:0] w_lat_max;
  logic [CW-1:0] w_div_cnt;
  logic          w_raw;
  logic          w_waw;
  logic          w_struct;
  logic          w_hazard;
  logic          w_go;
  logic          w_any_div;
  logic          w_illegal;
  logic          r_bundle_err;

  assign w_raw = (u_src_use[2] && (w_cnt[u_rs] != '0)) ||
                 (u_src_use[1] && (w_cnt[u_ra] != '0)) ||
                 (u_src_use[0] && (w_cnt[u_rb] != '0)) ||
                 (l_src_use[2] && (w_cnt[l_rs] != '0)) ||
                 (l_src_use[1] && (w_cnt[l_ra] != '0)) ||
                 (l_src_use[0] && (w_cnt[l_rb] != '0));
  assign w_waw = (u_we && (w_cnt[u_rt] != '0)) || (l_we && (w_cnt[l_rt] != '0));
  assign w_any_div = (u_cls == CLS_DIV) || (l_cls == CLS_DIV);
  assign w_struct  = w_any_div && (w_div_cnt != '0);
  assign w_hazard  = w_raw || w_waw || w_struct;
  assign w_go      = valid && !flush;
  assign interlock = w_go && w_hazard;
  assign issue     = w_go && !w_hazard;

  assign w_illegal = (u_we && ((l_src_use[2] && (l_rs == u_rt)) ||
                               (l_src_use[1] && (l_ra == u_rt)) ||
                               (l_src_use[0] && (l_rb == u_rt)))) ||
                     (u_we && l_we && (u_rt == l_rt)) ||
                     ((u_cls == CLS_DIV) && (l_cls == CLS_DIV));

  assign w_hit_u   = 32'(u_we) << u_rt;
  assign w_hit_l   = 32'(l_we) << l_rt;
  assign w_lat_u   = lat_of(u_cls);
  assign w_lat_l   = lat_of(l_cls);
  assign w_lat_max = (w_lat_u > w_lat_l) ? w_lat_u : w_lat_l;

  always_comb begin
    w_load = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      w_load[i]     = issue && (w_hit_u[i] || w_hit_l[i]);
      w_load_val[i] = (w_hit_u[i] && w_hit_l[i]) ? w_lat_max :
                      w_hit_u[i] ? w_lat_u : w_lat_l;
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_reg_cnt
    sb_counter #(.CW(CW)) u_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .i_load     (w_load[g]),
      .i_load_val (w_load_val[g]),
      .o_cnt      (w_cnt[g])
    );
  end

  sb_counter #(.CW(CW)) u_div_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (issue && w_any_div),
    .i_load_val (CW'(LAT_DIV - 1)),
    .o_cnt      (w_div_cnt)
  );

  assign div_busy = (w_div_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rstn)
      r_bundle_err <= 1'b0;
    else if (issue && w_illegal)
      r_bundle_err <= 1'b1;
  end

  assign bundle_err = r_bundle_err;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_div_stall_cycles;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cycles     <= '0;
      r_div_stall_cycles <= '0;
    end else begin
      if (interlock && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_go && w_struct && !w_raw && !w_waw && (r_div_stall_cycles != '1))
        r_div_stall_cycles <= r_div_stall_cycles + 1'b1;
    end
  end

  assign stall_cycles     = r_stall_cycles;
  assign div_stall_cycles = r_div_stall_cycles;
`endif

endmodule
